// File: rtl/klein_ctrl.sv
// klein_ctrl: control sequencer for a byte-serial KLEIN-64 round datapath.
// It runs one block per start: 8 load cycles, NROUNDS x 8 round cycles,
// and 8 output (final key-whitening) cycles. All outputs are decoded from
// registered state, so start and in_valid never reach an output combinationally.
//
// Ports:
//   ck        clock, rising edge
//   rst       asynchronous active-high reset
//   start     request a block; sampled only while ready=1
//   in_valid  plaintext/key byte pair present; must stay high through LOAD
//   ready     idle, able to accept start
//   in_ready  LOAD phase: datapath is taking input bytes
//   round0    datapath load select
//   round     current round number [0:3], MSB first
//   sels      state-path selects [0:3]
//   selk      key-schedule selects [0:3]
//   out_valid datapath output carries a ciphertext byte
//   done      pulse on the last ciphertext byte
//   err       pulse the cycle after a LOAD cycle without in_valid
module klein_ctrl #(
  parameter int NROUNDS = 12
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       ready,
  output logic       in_ready,
  output logic       round0,
  output logic [0:3] round,
  output logic [0:3] sels,
  output logic [0:3] selk,
  output logic       out_valid,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

  localparam logic [3:0] LAST_RND = 4'(NROUNDS);

  state_t     state, state_nxt;
  logic [2:0] step, step_nxt;
  logic [3:0] rnd, rnd_nxt;
  logic       abort_p1, abort_nxt;

  // State-path select per byte slot within a round.
  function automatic logic [0:3] sels_dec(input logic [2:0] s);
    case (s)
      3'd3:    sels_dec = 4'b1000;
      3'd5:    sels_dec = 4'b0100;
      3'd6:    sels_dec = 4'b0110;
      3'd7:    sels_dec = 4'b0111;
      default: sels_dec = 4'b0000;
    endcase
  endfunction

  // Key-schedule select: [0:1] rotate/mix path, [2] round-constant XOR,
  // [3] key S-box insert.
  function automatic logic [0:3] selk_dec(input logic [2:0] s);
    case (s)
      3'd4:    selk_dec = 4'b0111;
      3'd5:    selk_dec = 4'b0101;
      3'd6:    selk_dec = 4'b1000;
      3'd7:    selk_dec = 4'b1100;
      default: selk_dec = 4'b0000;
    endcase
  endfunction

  // State register
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      step     <= 3'd0;
      rnd      <= 4'd0;
      abort_p1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      step     <= step_nxt;
      rnd      <= rnd_nxt;
      abort_p1 <= abort_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    rnd_nxt   = rnd;
    abort_nxt = 1'b0;
    case (state)
      IDLE: begin
        step_nxt = 3'd0;
        rnd_nxt  = 4'd0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        step_nxt = step + 3'd1;
        if (!in_valid) begin
          // Any missing byte discards the whole block.
          state_nxt = IDLE;
          step_nxt  = 3'd0;
          abort_nxt = 1'b1;
        end else if (step == 3'd7) begin
          state_nxt = RUN;
          rnd_nxt   = 4'd1;
        end
      end
      RUN: begin
        step_nxt = step + 3'd1;
        if (step == 3'd7) begin
          if (rnd == LAST_RND) begin
            state_nxt = OUT;
            rnd_nxt   = 4'd0;
          end else begin
            rnd_nxt = rnd + 4'd1;
          end
        end
      end
      OUT: begin
        step_nxt = step + 3'd1;
        if (step == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready     = 1'b0;
    in_ready  = 1'b0;
    round0    = 1'b0;
    round     = 4'd0;
    sels      = 4'd0;
    selk      = 4'd0;
    out_valid = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        err   = abort_p1;
      end
      LOAD: begin
        round0   = 1'b1;
        in_ready = 1'b1;
      end
      RUN: begin
        round = rnd;
        sels  = sels_dec(step);
        selk  = selk_dec(step);
      end
      OUT: begin
        out_valid = 1'b1;
        done      = (step == 3'd7);
      end
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_klein_ctrl.sv
// Bench for klein_ctrl: expected per-cycle control vectors are queued when a
// block is launched; a negedge monitor pops one whenever the DUT is active.
module tb_klein_ctrl;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic rst, start0, in_valid0, start1, in_valid1;

  logic       a_ready, a_in_ready, a_round0, a_out_valid, a_done, a_err;
  logic [0:3] a_round, a_sels, a_selk;
  logic       b_ready, b_in_ready, b_round0, b_out_valid, b_done, b_err;
  logic [0:3] b_round, b_sels, b_selk;

  klein_ctrl #(.NROUNDS(12)) u0 (
    .ck(ck), .rst(rst), .start(start0), .in_valid(in_valid0),
    .ready(a_ready), .in_ready(a_in_ready), .round0(a_round0),
    .round(a_round), .sels(a_sels), .selk(a_selk),
    .out_valid(a_out_valid), .done(a_done), .err(a_err)
  );

  klein_ctrl #(.NROUNDS(1)) u1 (
    .ck(ck), .rst(rst), .start(start1), .in_valid(in_valid1),
    .ready(b_ready), .in_ready(b_in_ready), .round0(b_round0),
    .round(b_round), .sels(b_sels), .selk(b_selk),
    .out_valid(b_out_valid), .done(b_done), .err(b_err)
  );

  int tests = 0;
  int fails = 0;
  logic [17:0] q0[$];
  logic [17:0] q1[$];

  // Hand-written step tables; bit [0] of the 4-bit field is the MSB here.
  localparam logic [3:0] SELS_T [0:7] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h4, 4'h6, 4'h7};
  localparam logic [3:0] SELK_T [0:7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'h5, 4'h8, 4'hC};

  function automatic logic [17:0] mkvec(input logic rdy, input logic inr, input logic r0,
                                        input logic [3:0] rn, input logic [3:0] s,
                                        input logic [3:0] k, input logic ov,
                                        input logic dn, input logic er);
    return {rdy, inr, r0, rn, s, k, ov, dn, er};
  endfunction

  wire [17:0] a_vec = {a_ready, a_in_ready, a_round0, a_round, a_sels, a_selk,
                       a_out_valid, a_done, a_err};
  wire [17:0] b_vec = {b_ready, b_in_ready, b_round0, b_round, b_sels, b_selk,
                       b_out_valid, b_done, b_err};

  localparam logic [17:0] IDLE_V = 18'h20000;
  localparam logic [17:0] ERR_V  = 18'h20001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the first 'limit' expected vectors of a full block with nr rounds.
  task automatic push_block(input int which, input int nr, input int limit);
    logic [17:0] tmp[$];
    for (int i = 0; i < 8; i++) tmp.push_back(mkvec(0, 1, 1, 4'd0, 4'd0, 4'd0, 0, 0, 0));
    for (int r = 1; r <= nr; r++)
      for (int s = 0; s < 8; s++)
        tmp.push_back(mkvec(0, 0, 0, 4'(r), SELS_T[s], SELK_T[s], 0, 0, 0));
    for (int s = 0; s < 8; s++) tmp.push_back(mkvec(0, 0, 0, 4'd0, 4'd0, 4'd0, 1, s == 7, 0));
    for (int k = 0; k < limit && k < tmp.size(); k++)
      if (which == 0) q0.push_back(tmp[k]);
      else            q1.push_back(tmp[k]);
  endtask

  // Leaves the caller 1 time unit into cycle 1 (first LOAD cycle).
  task automatic issue_start(input int which);
    @(posedge ck); #1;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge ck); #1;
    if (which == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  always @(negedge ck) begin
    if (!rst && (!a_ready || a_err)) begin
      if (q0.size() == 0) chk("dut0 unexpected activity", {14'd0, a_vec}, {14'd0, IDLE_V});
      else                chk("dut0 cycle vector", {14'd0, a_vec}, {14'd0, q0.pop_front()});
    end
    if (!rst && (!b_ready || b_err)) begin
      if (q1.size() == 0) chk("dut1 unexpected activity", {14'd0, b_vec}, {14'd0, IDLE_V});
      else                chk("dut1 cycle vector", {14'd0, b_vec}, {14'd0, q1.pop_front()});
    end
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; in_valid0 = 1'b1; in_valid1 = 1'b1;
    repeat (2) @(posedge ck); #1;
    chk("reset outputs dut0", {14'd0, a_vec}, {14'd0, IDLE_V});
    chk("reset outputs dut1", {14'd0, b_vec}, {14'd0, IDLE_V});
    rst = 1'b0;
    @(posedge ck); #1;

    // Reset in round 5, step 2 (cycle 43)
    push_block(0, 12, 42);
    issue_start(0);
    repeat (42) @(posedge ck); #1;
    chk("round before reset", {28'd0, a_round}, 32'd5);
    rst = 1'b1; #1;
    chk("async reset outputs", {14'd0, a_vec}, {14'd0, IDLE_V});
    chk("queue drained before reset", q0.size(), 0);
    @(posedge ck); #1;
    rst = 1'b0;

    // Full trace with ignored starts during RUN and in the done cycle
    push_block(0, 12, 112);
    issue_start(0);
    chk("in_ready right after start", {31'd0, a_in_ready}, 32'd1);
    repeat (49) @(posedge ck); #1;
    start0 = 1'b1; in_valid0 = 1'b0;
    @(posedge ck); #1;
    start0 = 1'b0; in_valid0 = 1'b1;
    repeat (61) @(posedge ck); #1;
    chk("done at cycle 112", {31'd0, a_done}, 32'd1);
    start0 = 1'b1;
    @(posedge ck); #1;
    chk("ready after done", {31'd0, a_ready}, 32'd1);
    chk("done is one pulse", {31'd0, a_done}, 32'd0);
    push_block(0, 12, 4);
    q0.push_back(ERR_V);
    @(posedge ck); #1;
    start0 = 1'b0;
    chk("relaunch after done", {31'd0, a_in_ready}, 32'd1);

    // Load abort on LOAD cycle 4 of the relaunched block
    repeat (3) @(posedge ck); #1;
    in_valid0 = 1'b0;
    @(posedge ck); #1;
    in_valid0 = 1'b1;
    chk("err after abort", {31'd0, a_err}, 32'd1);
    chk("ready with err", {31'd0, a_ready}, 32'd1);
    @(posedge ck); #1;
    chk("err is one pulse", {31'd0, a_err}, 32'd0);
    repeat (3) @(posedge ck); #1;
    chk("idle after abort", {14'd0, a_vec}, {14'd0, IDLE_V});
    chk("dut0 queue drained", q0.size(), 0);

    // NROUNDS=1 instance
    push_block(1, 1, 24);
    issue_start(1);
    repeat (23) @(posedge ck); #1;
    chk("nrounds1 done at cycle 24", {31'd0, b_done}, 32'd1);
    @(posedge ck); #1;
    chk("nrounds1 ready after done", {31'd0, b_ready}, 32'd1);
    chk("dut1 queue drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
